rtc_bus_scheduler: RTL

RTC_BUS_SCHEDULER -- requirements
Module: rtc_bus_scheduler

---
 rtl/rtc_bus_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: shares one RTC register bus between the per-frame display
// refresh (a burst of reads into the display register file) and single-register
// writes from the edit logic. Edits take priority but never split a transaction.
module rtc_bus_scheduler #(
  parameter int         NUM_REGS  = 9,
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int         TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       edit_req,
  input  logic [3:0] edit_idx,
  input  logic [7:0] edit_data,
  output logic       edit_ack,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic       disp_we,
  output logic [3:0] disp_idx,
  output logic [7:0] disp_data,
  output logic       busy,
  output logic       err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_t;

  state_t        r_state;
  logic          r_pending;   // a frame_start arrived and its refresh has not begun
  logic          r_refresh;   // a refresh sequence is in progress
  logic          r_last_wr;   // the transaction that just finished was a write
  logic [3:0]    r_idx;       // refresh index of the current / last completed read
  logic [TW-1:0] r_tcnt;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [7:0]    r_bus_addr;
  logic [7:0]    r_bus_wdata;
  logic          r_edit_ack;
  logic          r_disp_we;
  logic [3:0]    r_disp_idx;
  logic [7:0]    r_disp_data;
  logic          r_err;

  logic          w_edit_ok;
  logic          w_last_idx;
  logic [3:0]    w_next_idx;

  // Decode of edit index validity and refresh progress
  always_comb begin
    w_edit_ok  = (edit_idx < 4'(NUM_REGS));
    w_last_idx = (r_idx == 4'(NUM_REGS - 1));
    w_next_idx = r_idx + 4'd1;
  end

  // Scheduler FSM with all outputs registered; strobes default low each cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_refresh   <= 1'b0;
      r_last_wr   <= 1'b0;
      r_idx       <= 4'd0;
      r_tcnt      <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 8'h00;
      r_bus_wdata <= 8'h00;
      r_edit_ack  <= 1'b0;
      r_disp_we   <= 1'b0;
      r_disp_idx  <= 4'd0;
      r_disp_data <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      r_edit_ack <= 1'b0;
      r_disp_we  <= 1'b0;
      r_err      <= 1'b0;
      if (frame_start) r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          // r_edit_ack guard: the requester is still holding the request it was just acked for
          if (edit_req && !r_edit_ack) begin
            if (w_edit_ok) begin
              r_state     <= WRITE;
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b1;
              r_bus_addr  <= BASE_ADDR + {4'd0, edit_idx};
              r_bus_wdata <= edit_data;
              r_tcnt      <= '0;
            end else begin
              r_edit_ack  <= 1'b1;
            end
          end else if (r_pending) begin
            // a frame_start in this same cycle belongs to the next frame
            r_pending   <= frame_start;
            r_refresh   <= 1'b1;
            r_idx       <= 4'd0;
            r_state     <= READ;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= BASE_ADDR;
            r_bus_wdata <= 8'h00;
            r_tcnt      <= '0;
          end
        end

        WRITE, READ: begin
          if (bus_done) begin
            r_bus_req <= 1'b0;
            r_tcnt    <= '0;
            r_state   <= GAP;
            r_last_wr <= (r_state == WRITE);
            if (r_state == WRITE) begin
              r_edit_ack  <= 1'b1;
            end else begin
              r_disp_we   <= 1'b1;
              r_disp_idx  <= r_idx;
              r_disp_data <= bus_rdata;
            end
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            // give up: the refresh is abandoned, a pending edit is retried from IDLE
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_refresh <= 1'b0;
            r_tcnt    <= '0;
            r_state   <= IDLE;
          end else begin
            r_tcnt    <= r_tcnt + TW'(1);
          end
        end

        GAP: begin
          if (edit_req && !r_last_wr && w_edit_ok) begin
            r_state     <= WRITE;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b1;
            r_bus_addr  <= BASE_ADDR + {4'd0, edit_idx};
            r_bus_wdata <= edit_data;
            r_tcnt      <= '0;
          end else begin
            if (edit_req && !r_last_wr) r_edit_ack <= 1'b1;
            if (r_refresh && !w_last_idx) begin
              r_idx       <= w_next_idx;
              r_state     <= READ;
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b0;
              r_bus_addr  <= BASE_ADDR + {4'd0, w_next_idx};
              r_bus_wdata <= 8'h00;
              r_tcnt      <= '0;
            end else begin
              r_refresh   <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign edit_ack  = r_edit_ack;
  assign disp_we   = r_disp_we;
  assign disp_idx  = r_disp_idx;
  assign disp_data = r_disp_data;
  assign err       = r_err;
  assign busy      = (r_state != IDLE);

endmodule
